a_stage_buf: RTL and testbench
==============================

// Module: a_stage_buf
// PURPOSE
//   Parametrised elastic pipeline stage: a DEPTH-entry circular buffer between two
//   valid/stall handshakes. Both stall_o and v_o/data_o come from flops only, so no
//   combinational stall_i->stall_o path exists and long stall chains are cut.
//   Adds a flush input and an occupancy count. Sits between processor pipeline stages.
// PARAMETERS
//   WORD   32  data width in bits
//   DEPTH  2   buffer entries, >= 2; need not be a power of two
//   CW     $clog2(DEPTH+1)  count width (derived; do not override)
// PORTS
//   clk      in   1      clock; all state updates on rising edge
//   rst      in   1      reset; synchronous, active-high
//   flush    in   1      1 = discard all buffered entries and the v_i beat
//   v_i      in   1      upstream valid
//   data_i   in   WORD   upstream data
//   stall_o  out  1      1 = upstream must hold v_i/data_i (buffer full)
//   v_o      out  1      downstream valid
//   data_o   out  WORD   downstream data (head entry)
//   stall_i  in   1      1 = downstream not accepting
//   count    out  CW     entries held, 0..DEPTH
// BEHAVIOUR
//   - push = v_i & ~stall_o & ~flush; pop = v_o & ~stall_i & ~flush.
//   - stall_o = (count == DEPTH). Depends on state only, never on stall_i or v_i.
//   - v_o = (count != 0). data_o = mem[rd_ptr] when v_o=1, else all zeros.
//   - Latency: push at edge t into empty buffer -> v_o=1, data_o=pushed data after
//     edge t. No same-cycle bypass from data_i to data_o.
//   - Pointers wr_ptr, rd_ptr run 0..DEPTH-1 and wrap DEPTH-1 -> 0.
//     The push writes mem[wr_ptr] and increments wr_ptr.
//     The pop increments rd_ptr.
//   - count_next = count + push - pop. Push and pop in the same cycle leave count
//     unchanged. This holds at any count where both are legal.
//   - Full (count==DEPTH) with pop: pop occurs and the push is refused (stall_o=1 that
//     cycle). stall_o drops on the next cycle. Full cannot pass through.
//   - Empty (count==0): pop impossible (v_o=0). A push alone makes count 1.
//   - Upstream contract: while stall_o=1, v_i/data_i are held. The block does not
//     check this.
//   - flush=1 at edge: count<=0, wr_ptr<=0, rd_ptr<=0. v_i that cycle is dropped.
//     Downstream beat presented that cycle is not counted as consumed. v_o=0 on the
//     next cycle. Memory contents need not clear.
//   - rst=1 at edge: same as flush. Outputs after edge: v_o=0, data_o=0, stall_o=0,
//     count=0. rst has priority over every other input. Reset mid-transfer loses all
//     entries.
//   - Storage order is strict FIFO. Data is never duplicated, reordered or lost except
//     via flush/rst.
// TESTING
//   - Reset: rst=1 for 2 cycles with v_i=1 -> v_o=0, data_o=0, stall_o=0, count=0.
//   - Streaming, DEPTH=2: v_i=1 every cycle, data 1,2,3..., stall_i=0 -> data_o
//     1,2,3... one cycle after each push, count stays 1, stall_o=0.
//   - Fill: stall_i=1, push 0xA,0xB (DEPTH=2) -> count=2, stall_o=1, held 0xC refused.
//     Release stall_i -> pops 0xA, then 0xB, then 0xC accepted, order A,B,C.
//   - Wrap, DEPTH=3: push/pop 10 beats with random stall_i -> output equals input
//     order. count never exceeds 3. Pointers wrap without loss.
//   - Flush: count=2, flush=1 with v_i=1,data_i=0x55 -> next cycle count=0, v_o=0.
//     0x55 never appears at data_o.
//   - Full plus pop, DEPTH=2: count=2, stall_i=0, v_i=1 -> count=1 next cycle, v_i
//     not accepted that cycle. Accepted the following cycle.

Source files
------------

// File: rtl/a_stage_buf.sv
`default_nettype none
// ============================================================================
// Module      : a_stage_buf
// Description : Elastic pipeline stage. A DEPTH-entry circular buffer sits
//               between two valid/stall handshakes. stall_o, v_o and count
//               come straight from flops, so a downstream stall never reaches
//               upstream in the same cycle. Supports flush and reports
//               occupancy.
// Revision    : 1.0 - initial release
// ============================================================================
module a_stage_buf #(
  parameter int WORD  = 32,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            v_i,
  input  logic [WORD-1:0] data_i,
  output logic            stall_o,
  output logic            v_o,
  output logic [WORD-1:0] data_o,
  input  logic            stall_i,
  output logic [CW-1:0]   count
);

  localparam int            PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] C_LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

  logic [WORD-1:0] r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            r_full;
  logic            r_valid;

  logic            w_push;
  logic            w_pop;
  logic [PW-1:0]   w_wr_inc;
  logic [PW-1:0]   w_rd_inc;
  logic [CW-1:0]   w_count_nxt;

  // Handshakes are qualified only by registered state, never by the opposite
  // side's input, which keeps stall_i -> stall_o free of any combinational path.
  assign w_push = v_i & ~r_full & ~flush & ~rst;
  assign w_pop  = r_valid & ~stall_i & ~flush & ~rst;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  assign w_wr_inc = (r_wr_ptr == C_LAST) ? '0 : r_wr_ptr + PW'(1);
  assign w_rd_inc = (r_rd_ptr == C_LAST) ? '0 : r_rd_ptr + PW'(1);

  // Next occupancy: simultaneous push and pop leave the count unchanged.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Control state; rst and flush both empty the buffer, rst taking priority.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= w_wr_inc;
      if (w_pop)  r_rd_ptr <= w_rd_inc;
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == C_FULL);
      r_valid <= (w_count_nxt != '0);
    end
  end

  // Storage write; contents are not cleared, the valid flag masks stale data.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= data_i;
  end

  assign stall_o = r_full;
  assign v_o     = r_valid;
  assign data_o  = r_valid ? r_mem[r_rd_ptr] : '0;
  assign count   = r_count;

endmodule
`default_nettype wire

// File: tb/tb_a_stage_buf.sv
`default_nettype none
// ============================================================================
// Module      : tb_a_stage_buf
// Description : Self-checking bench for a_stage_buf. Two instances (DEPTH=2
//               and DEPTH=3) share one stimulus; each has its own queue-based
//               reference model that predicts occupancy and output order.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_a_stage_buf;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        v_i = 1'b0;
  logic [31:0] data_i = '0;
  logic        stall_i = 1'b0;

  logic        so2, vo2, so3, vo3;
  logic [31:0] do2, do3;
  logic [1:0]  cnt2, cnt3;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Reference model state, indexed 0 -> DEPTH=2, 1 -> DEPTH=3.
  int          mcount [2];
  int          npop   [2];
  logic [31:0] q0 [$];
  logic [31:0] q1 [$];

  always #5 clk = ~clk;

  a_stage_buf #(.WORD(32), .DEPTH(2)) u_dut2 (
    .clk(clk), .rst(rst), .flush(flush), .v_i(v_i), .data_i(data_i),
    .stall_o(so2), .v_o(vo2), .data_o(do2), .stall_i(stall_i), .count(cnt2)
  );

  a_stage_buf #(.WORD(32), .DEPTH(3)) u_dut3 (
    .clk(clk), .rst(rst), .flush(flush), .v_i(v_i), .data_i(data_i),
    .stall_o(so3), .v_o(vo3), .data_o(do3), .stall_i(stall_i), .count(cnt3)
  );

  // Scoreboard: at mid-cycle, compare DUT state to the model, then apply the
  // handshake that the coming rising edge will perform.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int          d;
      bit          es, ev, push, pop;
      logic        a_so, a_vo;
      logic [31:0] a_do, expd;
      logic [1:0]  a_cnt;
      d     = (k == 0) ? 2 : 3;
      a_so  = (k == 0) ? so2  : so3;
      a_vo  = (k == 0) ? vo2  : vo3;
      a_do  = (k == 0) ? do2  : do3;
      a_cnt = (k == 0) ? cnt2 : cnt3;
      if (!chk_en) begin
        mcount[k] = 0;
        if (k == 0) q0.delete(); else q1.delete();
      end else begin
        es = (mcount[k] == d);
        ev = (mcount[k] != 0);
        n_tests++;
        if (a_so !== es) begin
          n_fail++;
          $display("FAIL sb_stall_o[D%0d]: got %b expected %b", d, a_so, es);
        end
        n_tests++;
        if (a_vo !== ev) begin
          n_fail++;
          $display("FAIL sb_v_o[D%0d]: got %b expected %b", d, a_vo, ev);
        end
        n_tests++;
        if (a_cnt !== 2'(mcount[k])) begin
          n_fail++;
          $display("FAIL sb_count[D%0d]: got %0d expected %0d", d, a_cnt, mcount[k]);
        end
        if (!ev) begin
          n_tests++;
          if (a_do !== 32'h0) begin
            n_fail++;
            $display("FAIL sb_idle_data[D%0d]: got %h expected 0", d, a_do);
          end
        end
        push = v_i && !es && !flush && !rst;
        pop  = ev && !stall_i && !flush && !rst;
        if (pop) begin
          expd = (k == 0) ? q0.pop_front() : q1.pop_front();
          npop[k]++;
          n_tests++;
          if (a_do !== expd) begin
            n_fail++;
            $display("FAIL sb_data[D%0d]: got %h expected %h", d, a_do, expd);
          end
        end
        if (push) begin
          if (k == 0) q0.push_back(data_i); else q1.push_back(data_i);
        end
        if (rst || flush) begin
          mcount[k] = 0;
          if (k == 0) q0.delete(); else q1.delete();
        end else begin
          mcount[k] = mcount[k] + int'(push) - int'(pop);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_reset();
    v_i = 1'b0; stall_i = 1'b0; flush = 1'b0; rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; v_i = 1'b1; data_i = 32'h77;
    cyc();
    chk_en = 1'b1;
    cyc();
    rst = 1'b0; v_i = 1'b0;
    n_tests++;
    if ({vo2, so2, cnt2, do2} !== 36'h0) begin
      n_fail++;
      $display("FAIL reset_d2: got v=%b s=%b c=%0d d=%h expected all zero", vo2, so2, cnt2, do2);
    end
    n_tests++;
    if ({vo3, so3, cnt3, do3} !== 36'h0) begin
      n_fail++;
      $display("FAIL reset_d3: got v=%b s=%b c=%0d d=%h expected all zero", vo3, so3, cnt3, do3);
    end
  endtask

  task automatic test_stream();
    idle_reset();
    for (int i = 1; i <= 8; i++) begin
      v_i = 1'b1; data_i = 32'(i);
      cyc();
      n_tests++;
      if (vo2 !== 1'b1 || do2 !== 32'(i) || cnt2 !== 2'd1 || so2 !== 1'b0) begin
        n_fail++;
        $display("FAIL stream[%0d]: got v=%b d=%h c=%0d s=%b expected v=1 d=%h c=1 s=0",
                 i, vo2, do2, cnt2, so2, i);
      end
    end
    v_i = 1'b0;
    cyc();
    n_tests++;
    if (cnt2 !== 2'd0) begin
      n_fail++;
      $display("FAIL stream_drain: got count %0d expected 0", cnt2);
    end
  endtask

  task automatic test_fill();
    idle_reset();
    stall_i = 1'b1;
    v_i = 1'b1; data_i = 32'hA; cyc();
    data_i = 32'hB; cyc();
    data_i = 32'hC; cyc();
    n_tests++;
    if (cnt2 !== 2'd2 || so2 !== 1'b1 || do2 !== 32'hA) begin
      n_fail++;
      $display("FAIL fill_full: got c=%0d s=%b d=%h expected c=2 s=1 d=a", cnt2, so2, do2);
    end
    stall_i = 1'b0;
    cyc();
    n_tests++;
    if (cnt2 !== 2'd1 || do2 !== 32'hB || so2 !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_pop_a: got c=%0d d=%h s=%b expected c=1 d=b s=0", cnt2, do2, so2);
    end
    cyc();
    v_i = 1'b0;
    n_tests++;
    if (cnt2 !== 2'd1 || do2 !== 32'hC) begin
      n_fail++;
      $display("FAIL fill_accept_c: got c=%0d d=%h expected c=1 d=c", cnt2, do2);
    end
    cyc();
  endtask

  task automatic test_full_pop();
    idle_reset();
    stall_i = 1'b1; v_i = 1'b1;
    data_i = 32'h21; cyc();
    data_i = 32'h22; cyc();
    data_i = 32'h23; stall_i = 1'b0;
    cyc();
    n_tests++;
    if (cnt2 !== 2'd1 || do2 !== 32'h22) begin
      n_fail++;
      $display("FAIL full_pop_refuse: got c=%0d d=%h expected c=1 d=22", cnt2, do2);
    end
    cyc();
    v_i = 1'b0;
    n_tests++;
    if (cnt2 !== 2'd1 || do2 !== 32'h23) begin
      n_fail++;
      $display("FAIL full_pop_accept: got c=%0d d=%h expected c=1 d=23", cnt2, do2);
    end
    cyc();
  endtask

  task automatic test_flush();
    bit seen55 = 1'b0;
    idle_reset();
    stall_i = 1'b1; v_i = 1'b1;
    data_i = 32'h31; cyc();
    data_i = 32'h32; cyc();
    flush = 1'b1; stall_i = 1'b0; data_i = 32'h55;
    cyc();
    flush = 1'b0; v_i = 1'b0;
    n_tests++;
    if (cnt2 !== 2'd0 || vo2 !== 1'b0 || do2 !== 32'h0) begin
      n_fail++;
      $display("FAIL flush_empty: got c=%0d v=%b d=%h expected c=0 v=0 d=0", cnt2, vo2, do2);
    end
    for (int i = 0; i < 4; i++) begin
      if (do2 === 32'h55 || do3 === 32'h55) seen55 = 1'b1;
      cyc();
    end
    n_tests++;
    if (seen55) begin
      n_fail++;
      $display("FAIL flush_drop: got 0x55 at data_o expected never");
    end
  endtask

  task automatic test_wrap();
    int  sent = 0;
    int  base;
    int  maxc = 0;
    int  budget = 0;
    bit  acc;
    idle_reset();
    base = npop[1];
    while ((sent < 10 || mcount[1] != 0) && budget < 300) begin
      stall_i = 1'($urandom_range(0, 1));
      v_i     = (sent < 10);
      data_i  = 32'h100 + 32'(sent);
      acc     = v_i && (mcount[1] != 3);
      cyc();
      if (acc) sent++;
      if (int'(cnt3) > maxc) maxc = int'(cnt3);
      budget++;
    end
    v_i = 1'b0; stall_i = 1'b0;
    n_tests++;
    if (npop[1] - base !== 10) begin
      n_fail++;
      $display("FAIL wrap_delivered: got %0d expected 10", npop[1] - base);
    end
    n_tests++;
    if (maxc > 3) begin
      n_fail++;
      $display("FAIL wrap_max_count: got %0d expected <=3", maxc);
    end
  endtask

  initial begin
    npop[0] = 0; npop[1] = 0;
    test_reset();
    test_stream();
    test_fill();
    test_full_pop();
    test_flush();
    test_wrap();
    cyc();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
